// File: rtl/muldiv_scheduler.sv
// Iterative multiply/divide sequencer beside the EX stage: shift-add multiply or restoring divide
// over WIDTH cycles, then sign fix-up into HI/LO, with a stall request toward the hazard unit.
module muldiv_scheduler #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             MulStartE,
  input  logic             DivStartE,
  input  logic             SignedE,
  input  logic             FlushE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             MfhiD,
  input  logic             MfloD,
  input  logic             MdStartD,
  output logic             Busy,
  output logic             MdStallD,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]  opb_q, opb_d, raw_a_q, raw_a_d, hi_q, hi_d, lo_q, lo_d;
  logic              is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic              div0_q, div0_d, done_q, done_d;
  logic              start_acc;

  logic [WIDTH-1:0]   mag_a, mag_b, quot, rem;
  logic [WIDTH:0]     mul_sum, div_diff;
  logic [2*WIDTH-1:0] prod;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      raw_a_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      raw_a_q   <= raw_a_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_acc) state_d = StRun;
      StRun:   if (cnt_q == LastCnt) state_d = StFix;
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mag_a    = (SignedE && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
    mag_b    = (SignedE && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
    // Partial remainder shifted left by one, pulling in the next dividend bit.
    div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
    prod     = neg_res_q ? -acc_q : acc_q;
    quot     = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem      = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    raw_a_d   = raw_a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_acc) begin
          // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
          acc_d     = {{WIDTH{1'b0}}, (MulStartE ? mag_b : mag_a)};
          opb_d     = MulStartE ? mag_a : mag_b;
          is_div_d  = ~MulStartE;
          neg_res_d = SignedE & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
          neg_rem_d = SignedE & SrcAE[WIDTH-1];
          div0_d    = ~MulStartE & (SrcBE == '0);
          raw_a_d   = SrcAE;
          cnt_d     = '0;
        end
      end
      StRun: begin
        cnt_d = cnt_q + CntW'(1);
        if (!is_div_q) begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else if (div_diff[WIDTH]) begin
          acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
      end
      StFix: begin
        done_d = 1'b1;
        if (!is_div_q) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (div0_q) begin
          hi_d = raw_a_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quot;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    Busy      = (state_q != StIdle);
    start_acc = (MulStartE | DivStartE) & ~FlushE & (state_q == StIdle);
    MdStallD  = (Busy | start_acc) & (MfhiD | MfloD | MdStartD);
    Done      = done_q;
    Hi        = hi_q;
    Lo        = lo_q;
  end

endmodule
